// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised majority-vote UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Parity mode encodings for the PARITY parameter
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic int unsigned bitcnt_w(input int unsigned data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, free-running bit timer and 3-sample mid-bit majority vote.
module uart_rx_sampler #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  input  logic restart,
  output logic rx_s,
  output logic bit_val,
  output logic bit_strobe,
  output logic bit_end
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] MID  = 16'(CLK_DIV / 2);

  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic        smp0_q, smp1_q;

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], uart_rx};
  end

  assign rx_s       = sync_q[1];
  assign bit_end    = (cnt_q == LAST);
  assign bit_strobe = (cnt_q == MID + 16'd1);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      smp0_q <= 1'b1;
      smp1_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == MID - 16'd1) smp0_q <= rx_s;
      if (cnt_q == MID)         smp1_q <= rx_s;
    end
  end

  // Third sample is the live value at the strobe point
  assign bit_val = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);

endmodule

// File: rtl/uart_rx_mv.sv
// Parametrised UART receiver: majority vote, parity/framing flags, valid/ready with overrun.
// Optional break detection (brk port) when UART_RX_MV_BREAK_DET_EN is defined.
module uart_rx_mv
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic [1:0]           err_out,
  output logic                 overrun
`ifdef UART_RX_MV_BREAK_DET_EN
  ,
  output logic                 brk
`endif
);

  localparam int unsigned BCW = bitcnt_w(DATA_BITS);

  rx_state_t            state_q, state_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic                 scnt_q, scnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic [1:0]           err_q, err_d;
  logic                 vld_q, vld_d, ovr_q, ovr_d;
  logic                 rx_s, bit_val, bit_strobe, bit_end, restart;
  logic                 frame_done, is_brk, idle_block, hold_restart;

  uart_rx_sampler #(.CLK_DIV(CLK_DIV)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .restart   (restart),
    .rx_s      (rx_s),
    .bit_val   (bit_val),
    .bit_strobe(bit_strobe),
    .bit_end   (bit_end)
  );

  assign restart = (state_d != state_q) || hold_restart;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    scnt_d     = scnt_q;
    sh_d       = sh_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s && !idle_block) begin
          state_d = START;
          bcnt_d  = '0;
          scnt_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (bit_strobe && bit_val) state_d = IDLE;
        else if (bit_end)          state_d = DATA;
      end
      DATA: begin
        if (bit_strobe) begin
          sh_d   = {bit_val, sh_q[DATA_BITS-1:1]};
          bcnt_d = bcnt_q + 1'b1;
        end
        if (bit_end && bcnt_q == BCW'(DATA_BITS))
          state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
      end
      uart_pkg::PARITY: begin
        if (bit_strobe) perr_d = ((^sh_q) ^ bit_val) != (PARITY == PAR_ODD);
        if (bit_end)    state_d = STOP;
      end
      STOP: begin
        // Leave at the last stop sample rather than the bit end to tolerate drift
        if (bit_strobe) begin
          if (!bit_val) ferr_d = 1'b1;
          if (scnt_q == 1'(STOP_BITS - 1)) begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end else begin
            scnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    err_d  = err_q;
    vld_d  = vld_q;
    ovr_d  = 1'b0;
    if (vld_q && dout_rdy) vld_d = 1'b0;
    if (frame_done && !is_brk) begin
      if (!vld_q || dout_rdy) begin
        dout_d = sh_q;
        err_d  = {perr_q, ferr_d};
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      scnt_q  <= 1'b0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dout_q  <= '0;
      err_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout     = dout_q;
  assign err_out  = err_q;
  assign dout_vld = vld_q;
  assign overrun  = ovr_q;

`ifdef UART_RX_MV_BREAK_DET_EN
  logic pbit_q, pbit_d, fst0_q, fst0_d, hold_q, hold_d, brk_q;

  always_comb begin
    pbit_d = pbit_q;
    fst0_d = fst0_q;
    hold_d = hold_q;
    if (state_q == uart_pkg::PARITY && bit_strobe)        pbit_d = bit_val;
    if (state_q == STOP && bit_strobe && scnt_q == 1'b0) fst0_d = !bit_val;
    if (is_brk)                                          hold_d = 1'b1;
    else if (state_q == IDLE && bit_end && rx_s)         hold_d = 1'b0;
  end

  // With a single stop bit the first stop sample is the live one
  assign is_brk = frame_done && (sh_q == '0) &&
                  ((PARITY == PAR_NONE) || !pbit_q) &&
                  ((scnt_q == 1'b0) ? !bit_val : fst0_q);
  assign idle_block   = hold_q;
  assign hold_restart = hold_q && (state_q == IDLE) && !rx_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pbit_q <= 1'b0;
      fst0_q <= 1'b0;
      hold_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      pbit_q <= pbit_d;
      fst0_q <= fst0_d;
      hold_q <= hold_d;
      brk_q  <= is_brk;
    end
  end

  assign brk = brk_q;
`else
  assign is_brk       = 1'b0;
  assign idle_block   = 1'b0;
  assign hold_restart = 1'b0;
`endif

endmodule
